// File: rtl/mem_stage_if.sv
// mem_stage_if: the signal bundle around the memory-access stage.
//
// Carries the execute->memory handshake and payload, the data-SRAM read data,
// the memory->writeback handshake and payload, and the status/forwarding
// outputs that the stage exports upstream.
//
// Modports:
//   slave  - the memory stage itself (consumes EX payload, produces WB payload)
//   master - the surrounding pipeline (execute, SRAM, writeback, decode)
//
// Signals:
//   EX_to_MEM_valid  upstream has a valid instruction
//   MEM_allow_in     stage can accept this cycle
//   to_MEM_data      execute payload, 117+CSR_NUM_WIDTH bits
//   data_sram_rdata  SRAM read data (valid the first cycle in this stage)
//   WB_allow_in      writeback can accept
//   MEM_to_WB_valid  valid toward writeback
//   to_WB_data       writeback payload, 145+CSR_NUM_WIDTH bits
//   mem_ex           resident valid instruction has an exception or ertn
//   MEM_forward      {fwd_dest[5], final_result[32], load_pending, fwd_op_csr}
interface mem_stage_if #(
    parameter int unsigned CSR_NUM_WIDTH = 14
);
    logic                          EX_to_MEM_valid;
    logic                          MEM_allow_in;
    logic [117+CSR_NUM_WIDTH-1:0]  to_MEM_data;
    logic [31:0]                   data_sram_rdata;
    logic                          WB_allow_in;
    logic                          MEM_to_WB_valid;
    logic [145+CSR_NUM_WIDTH-1:0]  to_WB_data;
    logic                          mem_ex;
    logic [38:0]                   MEM_forward;

    modport slave (
        input  EX_to_MEM_valid,
        input  to_MEM_data,
        input  data_sram_rdata,
        input  WB_allow_in,
        output MEM_allow_in,
        output MEM_to_WB_valid,
        output to_WB_data,
        output mem_ex,
        output MEM_forward
    );

    modport master (
        output EX_to_MEM_valid,
        output to_MEM_data,
        output data_sram_rdata,
        output WB_allow_in,
        input  MEM_allow_in,
        input  MEM_to_WB_valid,
        input  to_WB_data,
        input  mem_ex,
        input  MEM_forward
    );
endinterface

// File: rtl/mem_stage.sv
// mem_stage: memory-access pipeline stage between execute and writeback.
//
// Registers the execute payload, captures the synchronous data-SRAM read data
// on the instruction's first cycle in the stage (and holds it across writeback
// stalls), extracts byte/halfword loads with sign or zero extension, and
// selects the final result. Also reports exception-pending status upstream
// and forwarding information to decode.
//
// Ports:
//   clk        clock
//   reset      synchronous, active-high reset
//   csr_reset  pipeline flush from exception/ertn commit (same effect as reset)
//   bus        mem_stage_if.slave: EX/MEM and MEM/WB handshakes, payloads,
//              SRAM read data, mem_ex and MEM_forward
//
// Build option:
//   MEM_FWD_LOAD_EN  when defined, decode takes load data straight from
//                    MEM_forward, so load_pending is tied low. When undefined,
//                    load_pending flags a resident load so decode stalls.
module mem_stage #(
    parameter int unsigned CSR_NUM_WIDTH = 14
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       csr_reset,
    mem_stage_if.slave bus
);
    localparam int unsigned InW = 117 + CSR_NUM_WIDTH;

    // State
    logic            mem_valid_q, mem_valid_d;
    logic            fresh_q, fresh_d;
    logic [InW-1:0]  payload_q, payload_d;
    logic [31:0]     rdata_buf_q, rdata_buf_d;

    // Handshake
    logic            flush;
    logic            mem_allow_in;
    logic            accept;

    // Unpacked payload fields
    logic [31:0]              pc;
    logic [31:0]              alu_result;
    logic                     rd_1b;
    logic                     rd_2b;
    logic                     rd_4b;
    logic                     rd_signed;
    logic [4:0]               dest;
    logic                     gr_we;
    logic                     ex_sys;
    logic                     ex_brk;
    logic                     ex_adef;
    logic                     ex_adem;
    logic                     is_ertn;
    logic                     op_csr;
    logic [CSR_NUM_WIDTH-1:0] csr_num;
    logic [31:0]              csr_wmask;
    logic [4:0]               rj;

    // Load datapath
    logic [31:0] rdata;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_data;
    logic        is_load;
    logic [31:0] final_result;
    logic        load_pending;

    assign {pc, alu_result, rd_1b, rd_2b, rd_4b, rd_signed, dest, gr_we, ex_sys, ex_brk,
            ex_adef, ex_adem, is_ertn, op_csr, csr_num, csr_wmask, rj} = payload_q;

    // ready_go is always 1, so the stage only blocks when writeback does.
    always_comb begin
        flush        = reset | csr_reset;
        mem_allow_in = ~mem_valid_q | bus.WB_allow_in;
        accept       = bus.EX_to_MEM_valid & mem_allow_in;
    end

    always_comb begin
        mem_valid_d = mem_valid_q;
        payload_d   = payload_q;
        fresh_d     = 1'b0;
        rdata_buf_d = rdata_buf_q;
        // Flush wins over a same-cycle acceptance.
        if (flush) begin
            mem_valid_d = 1'b0;
            payload_d   = '0;
            fresh_d     = 1'b0;
            rdata_buf_d = '0;
        end else begin
            if (mem_allow_in) begin
                mem_valid_d = bus.EX_to_MEM_valid;
            end
            if (accept) begin
                payload_d = bus.to_MEM_data;
            end
            fresh_d = accept;
            // SRAM data is only valid on the first cycle; keep it for stalls.
            if (fresh_q) begin
                rdata_buf_d = bus.data_sram_rdata;
            end
        end
    end

    always_ff @(posedge clk) begin
        mem_valid_q <= mem_valid_d;
        fresh_q     <= fresh_d;
        payload_q   <= payload_d;
        rdata_buf_q <= rdata_buf_d;
    end

    always_comb begin
        rdata = fresh_q ? bus.data_sram_rdata : rdata_buf_q;

        case (alu_result[1:0])
            2'b00:   byte_sel = rdata[7:0];
            2'b01:   byte_sel = rdata[15:8];
            2'b10:   byte_sel = rdata[23:16];
            default: byte_sel = rdata[31:24];
        endcase

        // a[0] is ignored: misaligned halfwords were already trapped upstream.
        half_sel = alu_result[1] ? rdata[31:16] : rdata[15:0];

        if (rd_1b) begin
            load_data = {{24{rd_signed & byte_sel[7]}}, byte_sel};
        end else if (rd_2b) begin
            load_data = {{16{rd_signed & half_sel[15]}}, half_sel};
        end else begin
            load_data = rdata;
        end

        is_load      = rd_1b | rd_2b | rd_4b;
        final_result = is_load ? load_data : alu_result;
    end

`ifdef MEM_FWD_LOAD_EN
    assign load_pending = 1'b0;
`else
    assign load_pending = mem_valid_q & is_load;
`endif

    always_comb begin
        bus.MEM_allow_in    = mem_allow_in;
        bus.MEM_to_WB_valid = mem_valid_q;
        // vaddr is the raw address; writeback uses it as the BADV source.
        bus.to_WB_data      = {pc, final_result, alu_result, dest, gr_we, ex_sys, ex_brk,
                               ex_adef, ex_adem, is_ertn, op_csr, csr_num, csr_wmask, rj};
        bus.mem_ex          = mem_valid_q & (ex_sys | ex_brk | ex_adef | ex_adem | is_ertn);
        bus.MEM_forward     = {dest & {5{mem_valid_q}}, final_result, load_pending,
                               op_csr & mem_valid_q};
    end

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed self-checking bench for mem_stage.
module tb_mem_stage;
    localparam int unsigned W    = 14;
    localparam int unsigned InW  = 117 + W;
    localparam int unsigned OutW = 145 + W;

    // {rd_1b, rd_2b, rd_4b, rd_signed}
    localparam logic [3:0] LdB  = 4'b1001;
    localparam logic [3:0] LdBu = 4'b1000;
    localparam logic [3:0] LdH  = 4'b0101;
    localparam logic [3:0] LdHu = 4'b0100;
    localparam logic [3:0] LdW  = 4'b0010;
    localparam logic [3:0] NoLd = 4'b0000;
    // {gr_we, ex_SYS, ex_BRK, ex_ADEF, ex_ADEM, is_ertn, op_csr}
    localparam logic [6:0] GrWe  = 7'b1000000;
    localparam logic [6:0] Adem  = 7'b0000100;
    localparam logic [6:0] Ertn  = 7'b0000010;
    localparam logic [6:0] OpCsr = 7'b0000001;

`ifdef MEM_FWD_LOAD_EN
    localparam logic LpExp = 1'b0;
`else
    localparam logic LpExp = 1'b1;
`endif

    logic clk = 1'b0;
    logic reset;
    logic csr_reset;

    mem_stage_if #(.CSR_NUM_WIDTH(W)) bus ();

    mem_stage #(.CSR_NUM_WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .csr_reset (csr_reset),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [InW-1:0] mk(input logic [31:0] pc, input logic [31:0] alu,
                                          input logic [3:0] ld, input logic [4:0] dest,
                                          input logic [6:0] flags);
        logic [W-1:0] cn;
        logic [31:0]  wm;
        logic [4:0]   rj;
        cn = W'(14'h0123);
        wm = 32'hF0F0_0000;
        rj = 5'd9;
        return {pc, alu, ld, dest, flags, cn, wm, rj};
    endfunction

    function automatic logic [31:0] wb_pc();
        return bus.to_WB_data[OutW-1 -: 32];
    endfunction

    function automatic logic [31:0] wb_result();
        return bus.to_WB_data[OutW-33 -: 32];
    endfunction

    function automatic logic [31:0] wb_vaddr();
        return bus.to_WB_data[OutW-65 -: 32];
    endfunction

    // Present a load, let it enter the stage, supply its SRAM data, check result.
    task automatic run_load(input string tag, input logic [InW-1:0] p,
                            input logic [31:0] rd, input logic [31:0] exp);
        bus.EX_to_MEM_valid = 1'b1;
        bus.to_MEM_data     = p;
        tick();
        bus.EX_to_MEM_valid = 1'b0;
        bus.data_sram_rdata = rd;
        #1;
        check_eq(tag, {32'd0, wb_result()}, {32'd0, exp});
        check_eq({tag, "_valid"}, {63'd0, bus.MEM_to_WB_valid}, 64'd1);
    endtask

    initial begin
        reset               = 1'b1;
        csr_reset           = 1'b0;
        bus.EX_to_MEM_valid = 1'b0;
        bus.to_MEM_data     = '0;
        bus.data_sram_rdata = 32'h0;
        bus.WB_allow_in     = 1'b1;
        repeat (3) tick();

        check_eq("rst_allow_in", {63'd0, bus.MEM_allow_in}, 64'd1);
        check_eq("rst_to_wb_valid", {63'd0, bus.MEM_to_WB_valid}, 64'd0);
        check_eq("rst_mem_ex", {63'd0, bus.mem_ex}, 64'd0);
        check_eq("rst_forward", {25'd0, bus.MEM_forward}, 64'd0);
        reset = 1'b0;

        // Back-to-back loads: each enters the cycle after the previous one.
        run_load("ld_b",   mk(32'h10, 32'h1003, LdB,  5'd1, GrWe), 32'h80FF_1234, 32'hFFFF_FF80);
        run_load("ld_bu",  mk(32'h14, 32'h1003, LdBu, 5'd1, GrWe), 32'h80FF_1234, 32'h0000_0080);
        run_load("ld_b1",  mk(32'h18, 32'h1001, LdB,  5'd1, GrWe), 32'h80FF_1234, 32'h0000_0012);
        run_load("ld_bu2", mk(32'h1C, 32'h1002, LdBu, 5'd1, GrWe), 32'h80FF_1234, 32'h0000_00FF);
        run_load("ld_h",   mk(32'h20, 32'h2002, LdH,  5'd2, GrWe), 32'h9ABC_0000, 32'hFFFF_9ABC);
        run_load("ld_hu",  mk(32'h24, 32'h2000, LdHu, 5'd2, GrWe), 32'h0000_8001, 32'h0000_8001);
        run_load("ld_hu3", mk(32'h28, 32'h2003, LdHu, 5'd2, GrWe), 32'h9ABC_0000, 32'h0000_9ABC);
        run_load("ld_h0",  mk(32'h2C, 32'h2000, LdH,  5'd2, GrWe), 32'h0000_8001, 32'hFFFF_8001);

        // ld.w stalled three cycles by writeback; SRAM data changes after cycle one.
        bus.EX_to_MEM_valid = 1'b1;
        bus.to_MEM_data     = mk(32'h100, 32'h3000, LdW, 5'd7, GrWe);
        tick();
        bus.WB_allow_in     = 1'b0;
        bus.data_sram_rdata = 32'h1122_3344;
        bus.to_MEM_data     = mk(32'h104, 32'h55, NoLd, 5'd8, GrWe);
        #1;
        check_eq("stall0_result", {32'd0, wb_result()}, 64'h1122_3344);
        check_eq("stall0_allow_in", {63'd0, bus.MEM_allow_in}, 64'd0);
        check_eq("stall0_valid", {63'd0, bus.MEM_to_WB_valid}, 64'd1);
        for (int i = 0; i < 2; i++) begin
            tick();
            bus.data_sram_rdata = 32'hDEAD_BEEF;
            #1;
            check_eq("stall_result", {32'd0, wb_result()}, 64'h1122_3344);
            check_eq("stall_allow_in", {63'd0, bus.MEM_allow_in}, 64'd0);
            check_eq("stall_valid", {63'd0, bus.MEM_to_WB_valid}, 64'd1);
            check_eq("stall_pc", {32'd0, wb_pc()}, 64'h100);
        end
        bus.WB_allow_in = 1'b1;
        #1;
        check_eq("unstall_allow_in", {63'd0, bus.MEM_allow_in}, 64'd1);
        tick();
        bus.EX_to_MEM_valid = 1'b0;
        #1;
        check_eq("after_stall_pc", {32'd0, wb_pc()}, 64'h104);
        check_eq("after_stall_result", {32'd0, wb_result()}, 64'h55);
        check_eq("after_stall_vaddr", {32'd0, wb_vaddr()}, 64'h55);

        // Exception in the stage, then flush with a competing acceptance.
        bus.EX_to_MEM_valid = 1'b1;
        bus.to_MEM_data     = mk(32'h200, 32'h4001, NoLd, 5'd4, Adem);
        tick();
        bus.EX_to_MEM_valid = 1'b0;
        #1;
        check_eq("adem_mem_ex", {63'd0, bus.mem_ex}, 64'd1);
        csr_reset           = 1'b1;
        bus.EX_to_MEM_valid = 1'b1;
        bus.to_MEM_data     = mk(32'h204, 32'h4004, NoLd, 5'd6, GrWe);
        tick();
        csr_reset           = 1'b0;
        bus.EX_to_MEM_valid = 1'b0;
        #1;
        check_eq("flush_valid", {63'd0, bus.MEM_to_WB_valid}, 64'd0);
        check_eq("flush_mem_ex", {63'd0, bus.mem_ex}, 64'd0);
        check_eq("flush_allow_in", {63'd0, bus.MEM_allow_in}, 64'd1);
        check_eq("flush_fwd_dest", {59'd0, bus.MEM_forward[38:34]}, 64'd0);
        check_eq("flush_pc", {32'd0, wb_pc()}, 64'd0);

        // Flush while empty, with an instruction being offered.
        csr_reset           = 1'b1;
        bus.EX_to_MEM_valid = 1'b1;
        bus.to_MEM_data     = mk(32'h208, 32'h4008, NoLd, 5'd6, GrWe);
        tick();
        csr_reset           = 1'b0;
        bus.EX_to_MEM_valid = 1'b0;
        #1;
        check_eq("flush_empty_valid", {63'd0, bus.MEM_to_WB_valid}, 64'd0);

        // ertn also raises mem_ex.
        bus.EX_to_MEM_valid = 1'b1;
        bus.to_MEM_data     = mk(32'h20C, 32'h0, NoLd, 5'd0, Ertn);
        tick();
        bus.EX_to_MEM_valid = 1'b0;
        #1;
        check_eq("ertn_mem_ex", {63'd0, bus.mem_ex}, 64'd1);

        // Forwarding: resident load, then a non-load CSR op to the same dest.
        bus.EX_to_MEM_valid = 1'b1;
        bus.to_MEM_data     = mk(32'h300, 32'h5000, LdW, 5'd5, GrWe);
        tick();
        bus.data_sram_rdata = 32'hCAFE_0001;
        bus.to_MEM_data     = mk(32'h304, 32'h1234, NoLd, 5'd5, GrWe | OpCsr);
        #1;
        check_eq("ldw_fwd_dest", {59'd0, bus.MEM_forward[38:34]}, 64'd5);
        check_eq("ldw_fwd_result", {32'd0, bus.MEM_forward[33:2]}, 64'hCAFE_0001);
        check_eq("ldw_load_pending", {63'd0, bus.MEM_forward[1]}, {63'd0, LpExp});
        check_eq("ldw_fwd_op_csr", {63'd0, bus.MEM_forward[0]}, 64'd0);
        tick();
        bus.EX_to_MEM_valid = 1'b0;
        #1;
        check_eq("add_fwd_dest", {59'd0, bus.MEM_forward[38:34]}, 64'd5);
        check_eq("add_load_pending", {63'd0, bus.MEM_forward[1]}, 64'd0);
        check_eq("add_result", {32'd0, wb_result()}, 64'h1234);
        check_eq("add_fwd_op_csr", {63'd0, bus.MEM_forward[0]}, 64'd1);
        check_eq("add_mem_ex", {63'd0, bus.mem_ex}, 64'd0);
        tick();
        #1;
        check_eq("idle_fwd_dest", {59'd0, bus.MEM_forward[38:34]}, 64'd0);
        check_eq("idle_fwd_op_csr", {63'd0, bus.MEM_forward[0]}, 64'd0);
        check_eq("idle_valid", {63'd0, bus.MEM_to_WB_valid}, 64'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
